// File: rtl/ifmap_row_packer.sv
// Row-tagging feeder for the CNN IFmap buffer: adds {first,last} tag bits and an optional zero flush row.
// Latency: one cycle from input accept to IFmap_buffer_in; one word per cycle while the buffer stays ready.
// Backpressure: a single holding register; data_ready drops while the held word is stalled.
module ifmap_row_packer #(
  parameter int unsigned DATA_WIDTH        = 16,
  parameter int unsigned FILTER_SIZE_WIDTH = 5,
  parameter int unsigned LEN_WIDTH         = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [LEN_WIDTH-1:0]                 row_length,
  input  logic [LEN_WIDTH-1:0]                 num_rows,
  input  logic [FILTER_SIZE_WIDTH-1:0]         filter_size,
  input  logic                                 flush_en,
  input  logic [DATA_WIDTH-1:0]                data_in,
  input  logic                                 data_valid,
  output logic                                 data_ready,
  output logic [DATA_WIDTH+1:0]                IFmap_buffer_in,
  output logic                                 IFmap_buffer_write_enable,
  input  logic                                 IFmap_buffer_ready,
  input  logic                                 IFmap_buffer_full,
  output logic                                 busy,
  output logic                                 done,
  output logic [LEN_WIDTH+FILTER_SIZE_WIDTH-1:0] word_count
);

  localparam int unsigned WC_W = LEN_WIDTH + FILTER_SIZE_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t                       r_state;
  logic [LEN_WIDTH-1:0]         r_row_len;
  logic [LEN_WIDTH-1:0]         r_num_rows;
  logic [FILTER_SIZE_WIDTH-1:0] r_filt;
  logic                         r_flush_en;
  logic [LEN_WIDTH-1:0]         r_col;
  logic [LEN_WIDTH-1:0]         r_row;
  logic [FILTER_SIZE_WIDTH-1:0] r_fcol;
  logic [DATA_WIDTH+1:0]        r_out_dat;
  logic                         r_out_vld;
  logic                         r_busy;
  logic                         r_done;
  logic [WC_W-1:0]              r_word_count;

  logic       w_xfer;
  logic       w_slot;
  logic       w_accept;
  logic       w_fload;
  logic [1:0] w_stream_tag;
  logic [1:0] w_flush_tag;
  logic       w_last_col;
  logic       w_last_row;
  logic       w_last_fcol;

  // The held word leaves on a transfer edge; the slot is free when empty or emptying.
  assign w_xfer   = r_out_vld && IFmap_buffer_ready && !IFmap_buffer_full;
  assign w_slot   = !r_out_vld || w_xfer;
  assign data_ready = (r_state == STREAM) && w_slot;
  assign w_accept = data_ready && data_valid;
  assign w_fload  = (r_state == FLUSH) && w_slot;

  assign w_last_col   = (r_col == r_row_len - LEN_WIDTH'(1));
  assign w_last_row   = (r_row == r_num_rows - LEN_WIDTH'(1));
  assign w_last_fcol  = (r_fcol == r_filt - FILTER_SIZE_WIDTH'(1));
  assign w_stream_tag = {(r_col == '0), w_last_col};
  assign w_flush_tag  = {(r_fcol == '0), w_last_fcol};

  assign IFmap_buffer_in           = r_out_dat;
  assign IFmap_buffer_write_enable = r_out_vld;
  assign busy       = r_busy;
  assign done       = r_done;
  assign word_count = r_word_count;

  // Job FSM together with the holding register, position counters and word counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_row_len    <= '0;
      r_num_rows   <= '0;
      r_filt       <= '0;
      r_flush_en   <= 1'b0;
      r_col        <= '0;
      r_row        <= '0;
      r_fcol       <= '0;
      r_out_dat    <= '0;
      r_out_vld    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_done <= 1'b0;

      if (w_xfer) begin
        r_word_count <= r_word_count + WC_W'(1);
      end

      // A new load overwrites the slot even when the old word leaves on this edge.
      if (w_accept) begin
        r_out_dat <= {w_stream_tag, data_in};
        r_out_vld <= 1'b1;
      end else if (w_fload) begin
        r_out_dat <= {w_flush_tag, {DATA_WIDTH{1'b0}}};
        r_out_vld <= 1'b1;
      end else if (w_xfer) begin
        r_out_vld <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (start) begin
            r_row_len    <= row_length;
            r_num_rows   <= num_rows;
            r_filt       <= filter_size;
            r_flush_en   <= flush_en;
            r_word_count <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_fcol       <= '0;
            if (row_length != '0 && num_rows != '0) begin
              r_state <= STREAM;
              r_busy  <= 1'b1;
            end else begin
              // Empty job: nothing to send, complete immediately.
              r_done <= 1'b1;
            end
          end
        end

        STREAM: begin
          if (w_accept) begin
            if (w_last_col) begin
              r_col <= '0;
              if (w_last_row) begin
                r_fcol  <= '0;
                r_state <= (r_flush_en && r_filt != '0) ? FLUSH : DRAIN;
              end else begin
                r_row <= r_row + LEN_WIDTH'(1);
              end
            end else begin
              r_col <= r_col + LEN_WIDTH'(1);
            end
          end
        end

        FLUSH: begin
          if (w_fload) begin
            if (w_last_fcol) begin
              r_state <= DRAIN;
            end else begin
              r_fcol <= r_fcol + FILTER_SIZE_WIDTH'(1);
            end
          end
        end

        DRAIN: begin
          if (w_slot) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifmap_row_packer.sv
// Self-checking bench for ifmap_row_packer: directed jobs plus random jobs against a list-based model.
// Outputs are sampled 1 time unit after the falling edge; inputs change on the falling edge.
// Backpressure is exercised with always-ready, toggling-with-full and random buffer handshakes.
module tb_ifmap_row_packer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  row_length;
  logic [7:0]  num_rows;
  logic [4:0]  filter_size;
  logic        flush_en;
  logic [15:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic [17:0] IFmap_buffer_in;
  logic        IFmap_buffer_write_enable;
  logic        IFmap_buffer_ready;
  logic        IFmap_buffer_full;
  logic        busy;
  logic        done;
  logic [12:0] word_count;

  int tests;
  int fails;

  ifmap_row_packer dut (
    .clk                       (clk),
    .reset                     (reset),
    .start                     (start),
    .row_length                (row_length),
    .num_rows                  (num_rows),
    .filter_size               (filter_size),
    .flush_en                  (flush_en),
    .data_in                   (data_in),
    .data_valid                (data_valid),
    .data_ready                (data_ready),
    .IFmap_buffer_in           (IFmap_buffer_in),
    .IFmap_buffer_write_enable (IFmap_buffer_write_enable),
    .IFmap_buffer_ready        (IFmap_buffer_ready),
    .IFmap_buffer_full         (IFmap_buffer_full),
    .busy                      (busy),
    .done                      (done),
    .word_count                (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: buffer always ready, data always valid
  // mode 1: ready toggles each cycle, full held for three cycles mid-row
  // mode 2: random ready/full/valid
  task automatic run_job(input string name, input int len, input int rows, input int filt,
                         input bit fe, input int mode, input bit seq_data, input bit mid_start);
    logic [17:0] exp_q[$];
    logic [15:0] src_q[$];
    logic [17:0] got_q[$];
    logic [15:0] d;
    bit          seen_done;
    int          done_cyc;
    int          last_x;
    bit          prev_we;
    bit          prev_xfer;
    logic [17:0] prev_out;
    bit          xfer;

    // Reference: every row gives len words tagged {first,last}, then an optional zero flush row.
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < len; c++) begin
        d = seq_data ? 16'(r * len + c + 1) : 16'($urandom);
        src_q.push_back(d);
        exp_q.push_back({(c == 0), (c == len - 1), d});
      end
    end
    if (fe && filt != 0) begin
      for (int c = 0; c < filt; c++) begin
        exp_q.push_back({(c == 0), (c == filt - 1), 16'h0000});
      end
    end

    seen_done = 1'b0;
    done_cyc  = -1;
    last_x    = -1;
    prev_we   = 1'b0;
    prev_xfer = 1'b0;
    prev_out  = '0;

    @(negedge clk);
    start              = 1'b1;
    row_length         = 8'(len);
    num_rows           = 8'(rows);
    filter_size        = 5'(filt);
    flush_en           = fe;
    data_valid         = 1'b0;
    IFmap_buffer_ready = 1'b1;
    IFmap_buffer_full  = 1'b0;

    for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (mid_start && cyc == 4) begin
        start       = 1'b1;
        row_length  = 8'd1;
        num_rows    = 8'd1;
        filter_size = 5'd0;
        flush_en    = 1'b0;
      end
      case (mode)
        0: begin
          IFmap_buffer_ready = 1'b1;
          IFmap_buffer_full  = 1'b0;
          data_valid         = 1'b1;
        end
        1: begin
          IFmap_buffer_ready = (cyc % 2) == 0;
          IFmap_buffer_full  = (cyc >= 6 && cyc < 9);
          data_valid         = $urandom_range(0, 3) != 0;
        end
        default: begin
          IFmap_buffer_ready = $urandom_range(0, 3) != 0;
          IFmap_buffer_full  = $urandom_range(0, 7) == 0;
          data_valid         = $urandom_range(0, 3) != 0;
        end
      endcase
      data_in = (src_q.size() != 0) ? src_q[0] : 16'($urandom);
      #1;
      if (cyc == 0) check({name, "_busy_after_start"}, busy, 1);
      if (prev_we && !prev_xfer) begin
        check({name, "_stall_hold"}, {IFmap_buffer_write_enable, IFmap_buffer_in}, {1'b1, prev_out});
      end
      if (src_q.size() == 0) begin
        check({name, "_rdy_after_last"}, data_ready, 0);
      end else if (data_ready && data_valid) begin
        void'(src_q.pop_front());
      end
      xfer = IFmap_buffer_write_enable && IFmap_buffer_ready && !IFmap_buffer_full;
      if (xfer) begin
        got_q.push_back(IFmap_buffer_in);
        last_x = cyc;
      end
      if (done) begin
        seen_done = 1'b1;
        done_cyc  = cyc;
      end
      prev_we   = IFmap_buffer_write_enable;
      prev_xfer = xfer;
      prev_out  = IFmap_buffer_in;
    end

    check({name, "_done_seen"}, seen_done, 1);
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_w%0d", name, i), (i < got_q.size()) ? got_q[i] : 18'h3ffff, exp_q[i]);
    end
    check({name, "_done_timing"}, done_cyc, last_x + 1);
    check({name, "_word_count"}, word_count, exp_q.size());
    check({name, "_busy_at_done"}, busy, 0);
    @(negedge clk);
    data_valid = 1'b0;
    #1;
    check({name, "_done_one_cycle"}, done, 0);
    check({name, "_word_count_hold"}, word_count, exp_q.size());
  endtask

  task automatic degen(input string name, input int len, input int rows);
    @(negedge clk);
    start       = 1'b1;
    row_length  = 8'(len);
    num_rows    = 8'(rows);
    filter_size = 5'd3;
    flush_en    = 1'b1;
    data_valid  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check({name, "_done"}, done, 1);
    check({name, "_we"}, IFmap_buffer_write_enable, 0);
    check({name, "_busy"}, busy, 0);
    @(negedge clk);
    #1;
    check({name, "_done_off"}, done, 0);
    check({name, "_we_off"}, IFmap_buffer_write_enable, 0);
    data_valid = 1'b0;
  endtask

  initial begin
    int  nx;
    bit  any_done;
    tests = 0;
    fails = 0;
    reset              = 1'b0;
    start              = 1'b0;
    row_length         = '0;
    num_rows           = '0;
    filter_size        = '0;
    flush_en           = 1'b0;
    data_in            = '0;
    data_valid         = 1'b0;
    IFmap_buffer_ready = 1'b1;
    IFmap_buffer_full  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_we", IFmap_buffer_write_enable, 0);
    check("rst_out", IFmap_buffer_in, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wc", word_count, 0);
    check("rst_rdy", data_ready, 0);
    reset = 1'b1;

    run_job("basic", 10, 1, 5, 1'b1, 0, 1'b1, 1'b0);
    run_job("bp", 10, 1, 5, 1'b1, 1, 1'b1, 1'b0);
    run_job("single", 1, 3, 1, 1'b1, 0, 1'b0, 1'b0);
    run_job("multi", 4, 2, 5, 1'b0, 0, 1'b0, 1'b0);
    degen("deg_len0", 0, 3);
    degen("deg_rows0", 5, 0);
    run_job("midstart", 6, 2, 3, 1'b1, 2, 1'b0, 1'b1);

    // Reset in the middle of a job
    @(negedge clk);
    start       = 1'b1;
    row_length  = 8'd10;
    num_rows    = 8'd1;
    filter_size = 5'd5;
    flush_en    = 1'b1;
    nx = 0;
    for (int cyc = 0; cyc < 100 && nx < 6; cyc++) begin
      @(negedge clk);
      start              = 1'b0;
      data_valid         = 1'b1;
      data_in            = 16'($urandom);
      IFmap_buffer_ready = 1'b1;
      IFmap_buffer_full  = 1'b0;
      #1;
      if (IFmap_buffer_write_enable) nx++;
    end
    check("mid_rst_reached6", nx, 6);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_we", IFmap_buffer_write_enable, 0);
    check("mid_rst_out", IFmap_buffer_in, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_wc", word_count, 0);
    check("mid_rst_rdy", data_ready, 0);
    reset = 1'b1;
    any_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      if (done || IFmap_buffer_write_enable) any_done = 1'b1;
    end
    check("mid_rst_quiet", any_done, 0);
    data_valid = 1'b0;
    run_job("after_rst", 10, 1, 5, 1'b1, 0, 1'b1, 1'b0);

    // Random jobs
    for (int j = 0; j < 5; j++) begin
      run_job($sformatf("rnd%0d", j), $urandom_range(1, 7), $urandom_range(1, 3),
              $urandom_range(0, 4), 1'($urandom_range(0, 1)), 2, 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ifmap_row_packer.md
Name: ifmap_row_packer

Overview:
Upstream feeder for the CNN IFmap buffer. Takes raw signed ifmap words over a valid/ready stream and adds the 2-bit row framing tag the PE expects on IFmap_buffer_in: [W+1:W]=10 on the first word of a row, 01 on the last word, 00 otherwise, and 11 on a single-word row. After the last row it can append a zero "flush row" of filter_size words, so the PE emits its final psum. This replaces hand-built tagging in benches and system glue.

Parameters:
DATA_WIDTH, 16, raw ifmap word width; the output word is DATA_WIDTH+2 bits.
FILTER_SIZE_WIDTH, 5, width of filter_size; matches the CNN parameter.
LEN_WIDTH, 8, width of the row-length and row-count fields.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset (reset==0 on a rising edge resets)
start  in  1  one-cycle pulse; latches configuration; ignored while busy
row_length  in  LEN_WIDTH  words per row, sampled on start
num_rows  in  LEN_WIDTH  rows per job, sampled on start
filter_size  in  FILTER_SIZE_WIDTH  flush-row length, sampled on start
flush_en  in  1  append flush row after last row, sampled on start
data_in  in  DATA_WIDTH  raw ifmap word
data_valid  in  1  data_in valid
data_ready  out  1  packer accepts data_in this cycle
IFmap_buffer_in  out  DATA_WIDTH+2  tagged word {tag[1:0], data}
IFmap_buffer_write_enable  out  1  output word valid
IFmap_buffer_ready  in  1  buffer can accept
IFmap_buffer_full  in  1  buffer full
busy  out  1  job in progress
done  out  1  one-cycle pulse when the job completes
word_count  out  LEN_WIDTH+FILTER_SIZE_WIDTH  words delivered in the current or last job

Behaviour:
- Reset: all outputs are 0 and the FSM is in IDLE. Reset in the middle of a job aborts it, drops the held word, clears the counters, and produces no done pulse.
- Output transfer: occurs on a rising edge where IFmap_buffer_write_enable && IFmap_buffer_ready && !IFmap_buffer_full. IFmap_buffer_in and write_enable hold stable until the transfer happens.
- Output stage: a single holding register.
- data_ready = (state==STREAM) && (!write_enable || transfer). This gives full throughput: one word per cycle when the buffer stays ready.
- Latency: an input word accepted on edge N appears on IFmap_buffer_in after edge N, with write_enable high from then on.
- FSM states:
  - IDLE: on start with row_length!=0 and num_rows!=0, go to STREAM, clear word_count, set busy=1. If either is 0 on start, pulse done the next cycle and send no words.
  - STREAM: col and row counters advance on each accept. Tag is taken from col: col==0 gives bit1 set, col==row_length-1 gives bit0 set. After the last word of the last row is accepted, go to FLUSH if flush_en && filter_size!=0, else go to DRAIN.
  - FLUSH: generates filter_size zero words internally; data_ready=0. Tags use the same rule with filter_size as the length. After the last flush word is loaded, go to DRAIN.
  - DRAIN: wait for the held word to transfer, then pulse done for 1 cycle, set busy=0, go to IDLE.
- word_count increments on every output transfer and holds its value after done until the next start.
- Data is passed through unmodified; the tag occupies bits [DATA_WIDTH+1:DATA_WIDTH].
- data_valid while not in STREAM is ignored, and data_ready stays 0.
- A start pulse during busy has no effect and does not change the latched configuration.
- A backpressure flip (ready deasserting) in the same cycle as a load: the word stays held and no duplicate or loss occurs.

Test Plan:
- Basic row: row_length=10, num_rows=1, filter_size=5, flush_en=1, buffer always ready, data 1..10 -> 15 writes. Tags are 10,00×8,01 on data 1..10, then 10,00,00,00,01 on zero words. done pulses one cycle after the last transfer; word_count=15.
- Backpressure: same job with IFmap_buffer_ready toggling every other cycle and full asserted for 3 cycles mid-row -> identical 15-word sequence. Output is stable while stalled, with no loss or duplication.
- Single-word cases: row_length=1, num_rows=3, filter_size=1, flush_en=1 -> 4 words, all tagged 11, the last with data 0.
- Multi-row without flush: row_length=4, num_rows=2, flush_en=0 -> tags 10,00,00,01,10,00,00,01; done pulses; word_count=8; data_ready stays 0 after the 8th accept.
- Degenerate and ignored starts: start with row_length=0 -> done pulses in the next cycle and no write_enable. A second start pulse mid-job is ignored and the job output is unchanged.
- Reset mid-job: assert reset=0 after 6 words -> all outputs are 0 the next cycle and no done pulse. A fresh start then produces the full correct sequence.
